// File: rtl/alu_sequencer.sv
// Register-to-register sequencer around a combinational 4-bit ALU: holds a 4x4 register file,
// drives operands for a programmable settle time, then writes back the result and status.
module alu_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iValid,
    input  logic [13:0] iInstr,
    output logic        ready,
    output logic [3:0]  opCode,
    output logic [3:0]  aluA,
    output logic [3:0]  aluB,
    input  logic [3:0]  aluResult,
    input  logic [4:0]  aluStatus,
    output logic [4:0]  flags,
    output logic        done,
    input  logic [1:0]  rdSel,
    output logic [3:0]  rdData
);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] OpLoad  = 4'b0000;
    localparam logic [3:0] OpNop   = 4'b1111;

    state_e      state;
    logic [3:0]  regs [4];
    logic [13:0] instr;
    logic [3:0]  cnt;
    logic [4:0]  flags_r;

    logic [3:0] op;
    logic [1:0] dst;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] imm;

    assign op    = instr[13:10];
    assign dst   = instr[9:8];
    assign src_a = instr[7:6];
    assign src_b = instr[5:4];
    assign imm   = instr[3:0];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= StIdle;
            instr   <= '0;
            cnt     <= '0;
            flags_r <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (iValid) begin
                        instr <= iInstr;
                        cnt   <= CntInit;
                        state <= StExec;
                    end
                end
                StExec: begin
                    if (cnt == '0) begin
                        // Operands come straight from the file, so aliasing dst reads the old value.
                        if (op == OpLoad) begin
                            regs[dst] <= imm;
                        end else if (op != OpNop) begin
                            regs[dst] <= aluResult;
                            flags_r   <= aluStatus;
                        end
                        state <= StWb;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StWb: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        ready  = (state == StIdle);
        done   = (state == StWb);
        opCode = '0;
        aluA   = '0;
        aluB   = '0;
        if (state == StExec) begin
            opCode = op;
            aluA   = regs[src_a];
            aluB   = regs[src_b];
        end
    end

    assign flags  = flags_r;
    assign rdData = regs[rdSel];

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Upstream control stage for the 4-bit ALU. It accepts one encoded instruction at a time over a valid/ready handshake and holds a 4×4-bit register file. It drives the ALU's operand and opcode inputs from that file, waits a programmable settle time, then writes the ALU result back to the file and latches the 5-bit status word. It turns the combinational ALU into a small register-to-register execution unit.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: cycles operands and opcode are held stable before result/status capture; legal range 1..15.

Ports (clock and reset first):
- iClk  in  1  single clock; all state updates on rising edge
- iRst  in  1  reset, synchronous, active-high
- iValid  in  1  instruction present on iInstr
- iInstr  in  14  [13:10] op, [9:8] dst, [7:6] srcA, [5:4] srcB, [3:0] imm
- ready  out  1  block can accept an instruction this cycle
- opCode  out  4  opcode to ALU
- aluA  out  4  operand A to ALU
- aluB  out  4  operand B to ALU
- aluResult  in  4  ALU result
- aluStatus  in  5  ALU status, [P,Z,C,S,O] = bits [4:0]
- flags  out  5  last captured status
- done  out  1  one-cycle pulse at instruction completion
- rdSel  in  2  register file read select
- rdData  out  4  combinational read of reg[rdSel]

## Operation
- State machine: IDLE → EXEC → WB → IDLE.
- **IDLE**
  - ready=1; opCode=4'b0000, aluA=0, aluB=0.
  - iValid&&ready at an edge latches iInstr and loads the settle counter with SETTLE_CYCLES-1. Next state is EXEC.
  - iInstr is ignored when ready=0; iValid may stay high.
- **EXEC**
  - ready=0; opCode=latched op, aluA=reg[srcA], aluB=reg[srcB], all held stable.
  - The counter decrements each cycle. When it reads 0, the edge performs the capture and moves to WB.
- **Capture, by op**
  - 0001..1110: reg[dst]←aluResult and flags←aluStatus.
  - 0000 (LOAD): reg[dst]←imm; flags unchanged; ALU outputs ignored.
  - 1111 (NOP): no register write; flags unchanged.
- **WB**
  - done=1, ready=0; opCode returns to 0000.
  - Next edge returns to IDLE.
- **Operand/destination rules**
  - srcA, srcB and dst may alias. Operands are read before the write, so reg[dst] receives the result computed from the old value.
  - Operands are not latched separately: the register file cannot change during EXEC.
- rdData is purely combinational. During WB it shows the newly written value.
- No arithmetic in this block; widths are passed through unmodified. imm is 4 bits, stored unmodified.

## Timing
- **Reset**
  - While iRst=1 at an edge: all 4 registers←0, flags←0, state←IDLE, counter←0, latched instruction cleared.
  - Outputs during and after reset: ready=1 from the first cycle after reset; done=0; opCode/aluA/aluB=0.
- **Latency**
  - Accept at edge k.
  - EXEC covers cycles k..k+SETTLE_CYCLES.
  - Capture at edge k+SETTLE_CYCLES.
  - done=1 in the cycle after that edge.
  - ready=1 again after edge k+SETTLE_CYCLES+1.
- **Throughput:** one instruction per SETTLE_CYCLES+2 cycles (3 at default).
- **Reset mid-operation:** iRst in EXEC or WB aborts the instruction; no register or flag write, no done pulse.
- **Reset priority:** iRst and iValid together → reset wins; the instruction is not accepted.
- **Boundaries**
  - Back-to-back iValid is held off by ready=0 for SETTLE_CYCLES+1 cycles; no instruction is lost or duplicated.
  - The counter never wraps; SETTLE_CYCLES=1 means exactly one EXEC cycle.

## Test plan
- **Reset:** after reset, drive rdSel 0..3 → rdData=0 each; flags=0; ready=1; done=0.
- **LOAD:** op 0000, dst=1, imm=5 → reg1=5 two edges after accept; done high one cycle; flags unchanged; aluA/aluB/opCode stay 0.
- **ALU op capture** (ALU stub): preload reg1=5, reg2=3; issue op 0001, dst=3, srcA=1, srcB=2.
  - Required: opCode=0001, aluA=5, aluB=3 during EXEC.
  - Stub returns aluResult=4'h8, aluStatus=5'b10010 → reg3=8, flags=10010.
- **Aliasing + NOP:** reg1=5, op 0110, dst=src=1, stub result = aluA^aluB → reg1=0.
  - Then op 1111 → no register change, flags unchanged, done pulse.
- **SETTLE_CYCLES=4:** aluA/aluB/opCode held for exactly 4 cycles; capture at edge k+4; done at cycle k+5.
  - iValid held high throughout → exactly one acceptance per 6 cycles.
- **Reset mid-EXEC:** assert iRst in the 2nd EXEC cycle → no write to dst, no done, ready=1 the next cycle.
